// File: rtl/woz_bit_streamer.sv
// woz_bit_streamer: serialises a WOZ track from BRAM port B into a timed MSB-first bit-cell stream.
// Pauses on motor off / track not loaded; wraps at the (clamped) WOZ bit count.
module woz_bit_streamer #(
   parameter int ADDR_W       = 13,
   parameter int CLKS_PER_BIT = 56
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              motor_on,
   input  logic              track_valid,
   input  logic [15:0]       track_bit_count,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_data,
   output logic              bit_out,
   output logic              bit_strobe,
   output logic [15:0]       bit_pos,
   output logic              index_pulse
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [16:0] MAX_BITS = 17'(8 << ADDR_W);
   localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;

   logic [15:0]   pos, e, pos_n;
   logic [16:0]   cnt, e_inc;
   logic [CW-1:0] cell_cnt;
   logic          go, emit, cur;

   always_comb begin
      cnt     = ({1'b0, track_bit_count} > MAX_BITS) ? MAX_BITS : {1'b0, track_bit_count};
      go      = motor_on & track_valid & (cnt != '0);
      e       = ({1'b0, pos} >= cnt) ? '0 : pos;
      e_inc   = {1'b0, e} + 17'd1;
      pos_n   = (e_inc == cnt) ? '0 : e_inc[15:0];
      cur     = ram_data[3'd7 - e[2:0]];
      state_n = go ? RUN : IDLE;
      emit    = (state == RUN) & go & (cell_cnt == '0);
   end

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_n;

   // Between emits ram_addr tracks e so a shrunken count re-points the read at byte 0.
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         pos         <= '0;
         cell_cnt    <= '0;
         ram_addr    <= '0;
         bit_out     <= 1'b0;
         bit_strobe  <= 1'b0;
         bit_pos     <= '0;
         index_pulse <= 1'b0;
      end else begin
         bit_strobe  <= emit;
         index_pulse <= emit & (e == '0);
         ram_addr    <= emit ? pos_n[ADDR_W+2:3] : e[ADDR_W+2:3];
         pos         <= emit ? pos_n : pos;
         bit_pos     <= emit ? e : bit_pos;
         bit_out     <= emit ? cur : (state == RUN && !go) ? 1'b0 : bit_out;
         cell_cnt    <= emit ? CELL_LAST : (state == RUN && go) ? cell_cnt - 1'b1 : '0;
      end
endmodule
